alu_arbiter: RTL and testbench

- Shares the single 32-bit combinational ALU among NUM_REQ requesters using a round-robin grant.
- Accepts one operation at a time over a valid/ready handshake and registers the operands.
- Drives the ALU for exactly one cycle, then returns the registered result, zero flag and requester ID on a shared response channel.
- Sits between the multi-cycle datapath clients and the ALU instance; the ALU is external to this block.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_arbiter_rr_arbiter.sv | 31 +++
 rtl/alu_arbiter.sv | 103 ++++++++++
 tb/tb_alu_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice:
// ALU control codes, FSM encoding and op legality.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(
    input logic [3:0] op
  );
    logic ok;
    ok = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND,
      ALU_OR,  ALU_SLT: ok = 1'b1;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1
// modulo N and returns a one-hot grant plus index.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU among NUM_REQ
// requesters with round-robin grant.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]     req_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [3:0]               alu_ctrl,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_zero,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_zero,
  output logic                     rsp_err,
  output logic                     busy
);

  state_t state_q, state_d;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic               accept;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         op_q;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // Gate with rst_n so no accept is offered while reset is held
  assign accept    = rst_n && (state_q == IDLE) && gnt_any;
  assign req_ready = accept ? gnt : '0;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        a_q    <= req_a[int'(gnt_idx)*WIDTH +: WIDTH];
        b_q    <= req_b[int'(gnt_idx)*WIDTH +: WIDTH];
        op_q   <= req_op[int'(gnt_idx)*4 +: 4];
        id_q   <= gnt_idx;
        rr_ptr <= gnt_idx;
      end
      if (state_q == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_err    <= ~is_legal_op(op_q);
        rsp_id     <= id_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a
// behavioural ALU model on the ALU ports.
module tb_alu_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*4-1:0] req_op;
  logic [W-1:0]   alu_a, alu_b;
  logic [3:0]     alu_ctrl;
  logic [W-1:0]   alu_result;
  logic           alu_zero;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_zero;
  logic           rsp_err;
  logic           busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0111: alu_result = {31'd0, alu_a < alu_b};
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic set_req(
    input int          i,
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_op[i*4 +: 4] = op;
  endtask

  task automatic do_op(
    input string       tag,
    input int          i,
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] er,
    input logic        ez,
    input logic        ee
  );
    set_req(i, op, a, b);
    req_valid[i] = 1'b1;
    #1;
    chk({tag, " ready"}, 32'(req_ready), 32'd1 << i);
    step();
    req_valid[i] = 1'b0;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " early"}, 32'(rsp_valid), 32'd0);
    step();
    chk({tag, " valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, " result"}, rsp_result, er);
    chk({tag, " zero"}, 32'(rsp_zero), 32'(ez));
    chk({tag, " id"}, 32'(rsp_id), 32'(i));
    chk({tag, " err"}, 32'(rsp_err), 32'(ee));
    step();
    chk({tag, " drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    #1;
    chk("rst ready", 32'(req_ready), 32'd0);
    chk("rst rvalid", 32'(rsp_valid), 32'd0);
    chk("rst id", 32'(rsp_id), 32'd0);
    chk("rst result", rsp_result, 32'd0);
    chk("rst zero", 32'(rsp_zero), 32'd0);
    chk("rst err", 32'(rsp_err), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst alu_a", alu_a, 32'd0);
    chk("rst alu_b", alu_b, 32'd0);
    chk("rst ctrl", 32'(alu_ctrl), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    do_op("add", 0, 4'b0010, 32'd5, 32'd7,
          32'd12, 1'b0, 1'b0);
    do_op("sub", 0, 4'b0110, 32'd9, 32'd9,
          32'd0, 1'b1, 1'b0);
    do_op("and", 0, 4'b0000, 32'hF0F0_F0F0,
          32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0);
    do_op("or", 0, 4'b0001, 32'hF0F0_F0F0,
          32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1'b0);
    do_op("slt", 0, 4'b0111, 32'd3, 32'd8,
          32'd1, 1'b0, 1'b0);
    do_op("sltu", 0, 4'b0111, 32'hFFFF_FFFF,
          32'd1, 32'd0, 1'b1, 1'b0);

    // fresh reset so requester 0 leads
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++)
      set_req(i, 4'b0010, 32'(i), 32'd10);
    req_valid = 4'hF;
    #1;
    for (int g = 0; g < 6; g++) begin
      chk("sat grant", 32'(req_ready),
          32'd1 << (g % 4));
      step();
      chk("sat exec hold", 32'(req_ready), 32'd0);
      step();
      chk("sat id", 32'(rsp_id), 32'(g % 4));
      chk("sat result", rsp_result,
          32'(10 + g % 4));
      chk("sat resp hold", 32'(req_ready), 32'd0);
      step();
    end
    req_valid = '0;
    step();

    rsp_ready = 1'b0;
    set_req(2, 4'b0010, 32'd100, 32'd23);
    req_valid = 4'b0100;
    #1;
    chk("bp grant", 32'(req_ready), 32'h4);
    step();
    set_req(0, 4'b0010, 32'd1, 32'd1);
    req_valid = 4'b0001;
    step();
    chk("bp valid", 32'(rsp_valid), 32'd1);
    chk("bp result", rsp_result, 32'd123);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("bp hold valid", 32'(rsp_valid), 32'd1);
      chk("bp hold result", rsp_result, 32'd123);
      chk("bp hold id", 32'(rsp_id), 32'd2);
      chk("bp no ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp released", 32'(rsp_valid), 32'd0);
    chk("bp next grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    step();
    chk("bp next id", 32'(rsp_id), 32'd0);
    chk("bp next result", rsp_result, 32'd2);
    step();

    do_op("illegal", 1, 4'b1111, 32'd1, 32'd1,
          32'd0, 1'b1, 1'b1);

    set_req(1, 4'b0010, 32'd5, 32'd5);
    req_valid = 4'b0010;
    #1;
    chk("mid grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    chk("mid busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst alu_a", alu_a, 32'd0);
    chk("mid rst ctrl", 32'(alu_ctrl), 32'd0);
    chk("mid rst result", rsp_result, 32'd0);
    set_req(3, 4'b0010, 32'd7, 32'd8);
    set_req(0, 4'b0010, 32'd1, 32'd2);
    req_valid = 4'b1001;
    #1;
    chk("mid rst ready", 32'(req_ready), 32'd0);
    step();
    chk("mid no rsp", 32'(rsp_valid), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("post rst grant", 32'(req_ready), 32'h1);
    step();
    step();
    chk("post rst valid", 32'(rsp_valid), 32'd1);
    chk("post rst id0", 32'(rsp_id), 32'd0);
    chk("post rst res0", rsp_result, 32'd3);
    step();
    chk("post rst grant3", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    step();
    chk("post rst id3", 32'(rsp_id), 32'd3);
    chk("post rst res3", rsp_result, 32'd15);
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
